// File: rtl/fifo_pkg.sv
// Shared types and constants for the 32x8 FIFO sequencing controller.
package fifo_pkg;
  localparam int FIFO_DEPTH = 32;
  localparam int FIFO_AW    = 5;
  localparam int FIFO_DW    = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  typedef enum logic {OP_WR, OP_RD} op_t;
endpackage

// File: rtl/fifo_ctrl_32x8_if.sv
// Client handshake and RAM-side bus of the FIFO controller.
interface fifo_ctrl_32x8_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [AW-1:0] ram_addr;
  logic          ram_rw_sel;
  logic          ram_cs;
  logic [DW-1:0] ram_wdata;
  logic          ram_wdata_oe;
  logic [DW-1:0] ram_rdata;
  logic          ovf_err;
  logic          udf_err;

  modport master (
    output wr_valid, wr_data, rd_req, ram_rdata,
    input  wr_ready, rd_ready, rd_data, rd_valid, full, empty, count,
           ram_addr, ram_rw_sel, ram_cs, ram_wdata, ram_wdata_oe,
           ovf_err, udf_err
  );

  modport slave (
    input  wr_valid, wr_data, rd_req, ram_rdata,
    output wr_ready, rd_ready, rd_data, rd_valid, full, empty, count,
           ram_addr, ram_rw_sel, ram_cs, ram_wdata, ram_wdata_oe,
           ovf_err, udf_err
  );
endinterface

// File: rtl/fifo_ptr.sv
// AW-bit wrapping pointer with synchronous reset and increment enable.
module fifo_ptr #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk) begin
    if (rst)      ptr <= '0;
    else if (inc) ptr <= ptr + AW'(1);
  end
endmodule

// File: rtl/fifo_ctrl_32x8.sv
// Turns a 32x8 single-port RAM into a byte FIFO: arbitration, pointers, count, RAM sequencing.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl_32x8
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW,
  parameter int DW    = FIFO_DW
) (
  input  logic             clk,
  input  logic             rst,
  fifo_ctrl_32x8_if.slave  bus
);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_t        state, state_n;
  op_t           last_op;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [DW-1:0] wbuf, rd_data;
  logic          rd_valid;
  logic          full, empty;
  logic          wr_elig, rd_elig, wr_grant, rd_grant;
  logic          wr_rdy, rd_rdy;
  logic          ram_cs, ram_rw, ram_oe;
  logic [AW-1:0] ram_addr;

  // Flags come from the count only, so pointer equality never matters.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  always_comb begin
    state_n  = state;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    wr_rdy   = 1'b0;
    rd_rdy   = 1'b0;
    wr_elig  = bus.wr_valid && !full;
    rd_elig  = bus.rd_req && !empty;
    case (state)
      IDLE: begin
        // Round-robin: on contention, the op not done last wins.
        wr_grant = wr_elig && (!rd_elig || last_op == OP_RD);
        rd_grant = rd_elig && !wr_grant;
        wr_rdy   = !full && !rd_grant;
        rd_rdy   = !empty && !wr_grant;
        if (wr_grant)      state_n = WR;
        else if (rd_grant) state_n = RD;
      end
      WR, RD:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_op <= OP_RD;
    end else begin
      state <= state_n;
      if (wr_grant)      last_op <= OP_WR;
      else if (rd_grant) last_op <= OP_RD;
    end
  end

  fifo_ptr #(.AW(AW)) u_wptr (.clk(clk), .rst(rst), .inc(state == WR), .ptr(wptr));
  fifo_ptr #(.AW(AW)) u_rptr (.clk(clk), .rst(rst), .inc(state == RD), .ptr(rptr));

  // RAM controls are registered on the accept edge so they are clean for the whole access cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ram_cs   <= 1'b0;
      ram_rw   <= RW_READ;
      ram_oe   <= 1'b0;
      ram_addr <= '0;
    end else begin
      rd_valid <= 1'b0;
      ram_cs   <= wr_grant || rd_grant;
      ram_rw   <= wr_grant ? RW_WRITE : RW_READ;
      ram_oe   <= wr_grant;
      if (wr_grant) begin
        wbuf     <= bus.wr_data;
        ram_addr <= wptr;
      end else if (rd_grant) begin
        ram_addr <= rptr;
      end
      case (state)
        WR: count <= count + CNT_ONE;
        RD: begin
          count    <= count - CNT_ONE;
          rd_data  <= bus.ram_rdata;
          rd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.wr_valid && full) ovf_q <= 1'b1;
      if (bus.rd_req && empty)  udf_q <= 1'b1;
    end
  end

  assign bus.ovf_err = ovf_q;
  assign bus.udf_err = udf_q;
`else
  assign bus.ovf_err = 1'b0;
  assign bus.udf_err = 1'b0;
`endif

  assign bus.wr_ready     = wr_rdy;
  assign bus.rd_ready     = rd_rdy;
  assign bus.rd_data      = rd_data;
  assign bus.rd_valid     = rd_valid;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.ram_addr     = ram_addr;
  assign bus.ram_rw_sel   = ram_rw;
  assign bus.ram_cs       = ram_cs;
  assign bus.ram_wdata    = wbuf;
  assign bus.ram_wdata_oe = ram_oe;
endmodule

// File: tb/tb_fifo_ctrl_32x8.sv
// Directed bench for fifo_ctrl_32x8 with a behavioural 32x8 RAM and a queue reference.
module tb_fifo_ctrl_32x8;
`ifdef FIFO_CTRL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk, rst;
  int   checks, errors;

  fifo_ctrl_32x8_if #(.AW(5), .DW(8)) bus ();

  fifo_ctrl_32x8 dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, asynchronous read when selected for read.
  logic [7:0] mem [32];
  always @(posedge clk)
    if (bus.ram_cs && bus.ram_rw_sel) mem[bus.ram_addr] <= bus.ram_wdata;
  assign bus.ram_rdata = (bus.ram_cs && !bus.ram_rw_sel) ? mem[bus.ram_addr] : 8'h00;

  logic [7:0] q [$];
  logic [4:0] mw, mr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called one step after a rising edge with the controller idle.
  task automatic wr(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    #1 chk("wr_ready", bus.wr_ready, 1);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    chk("wr_cs", bus.ram_cs, 1);
    chk("wr_rw", bus.ram_rw_sel, 1);
    chk("wr_addr", bus.ram_addr, mw);
    chk("wr_oe", bus.ram_wdata_oe, 1);
    chk("wr_wdata", bus.ram_wdata, d);
    chk("wr_rdvalid_lo", bus.rd_valid, 0);
    @(posedge clk); #1;
    q.push_back(d);
    mw = mw + 5'd1;
    chk("wr_count", bus.count, q.size());
    chk("wr_empty", bus.empty, 0);
    chk("wr_full", bus.full, q.size() == 32);
  endtask

  task automatic rd();
    logic [7:0] e;
    bus.rd_req = 1'b1;
    #1 chk("rd_ready", bus.rd_ready, 1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    chk("rd_cs", bus.ram_cs, 1);
    chk("rd_rw", bus.ram_rw_sel, 0);
    chk("rd_addr", bus.ram_addr, mr);
    chk("rd_oe", bus.ram_wdata_oe, 0);
    chk("rd_valid_lo", bus.rd_valid, 0);
    @(posedge clk); #1;
    e = q.pop_front();
    mr = mr + 5'd1;
    chk("rd_valid", bus.rd_valid, 1);
    chk("rd_data", bus.rd_data, e);
    chk("rd_count", bus.count, q.size());
    chk("rd_empty", bus.empty, q.size() == 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_wr;
    logic [7:0] nd;
    checks = 0; errors = 0;
    mw = '0; mr = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_cs", bus.ram_cs, 0);
    chk("rst_rw", bus.ram_rw_sel, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_oe", bus.ram_wdata_oe, 0);
    chk("rst_ovf", bus.ovf_err, 0);
    chk("rst_udf", bus.udf_err, 0);

    wr(8'hA5);
    wr(8'h11);
    rd();
    rd();
    chk("idle_rd_valid_drop", bus.rd_valid, 1);
    @(posedge clk); #1;
    chk("rd_valid_pulse_end", bus.rd_valid, 0);

    // Fill to full, then try one more write.
    for (int i = 0; i < 32; i++) wr(8'(i));
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    #1 chk("full_wr_ready", bus.wr_ready, 0);
    chk("full_flag", bus.full, 1);
    chk("full_count", bus.count, 32);
    chk("full_rd_ready", bus.rd_ready, 1);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    chk("full_no_cs", bus.ram_cs, 0);
    chk("full_count_hold", bus.count, 32);
    chk("ovf_err", bus.ovf_err, ERR_EN);
    for (int i = 0; i < 32; i++) rd();

    // Interleaved traffic across the 31 -> 0 pointer wrap.
    for (int i = 0; i < 40; i++) begin
      wr(8'(8'h40 + i));
      rd();
    end

    // Contention with both requests held at count 5; last op was a write.
    for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
    exp_wr = 1'b0;
    nd = 8'hD0;
    bus.wr_valid = 1'b1;
    bus.rd_req   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wr_data = nd;
      #1 chk("arb_wr_ready", bus.wr_ready, exp_wr);
      chk("arb_rd_ready", bus.rd_ready, !exp_wr);
      @(posedge clk); #1;
      chk("arb_rw", bus.ram_rw_sel, exp_wr);
      chk("arb_addr", bus.ram_addr, exp_wr ? mw : mr);
      @(posedge clk); #1;
      if (exp_wr) begin
        q.push_back(nd);
        mw = mw + 5'd1;
        nd = nd + 8'd1;
      end else begin
        chk("arb_rd_data", bus.rd_data, q.pop_front());
        mr = mr + 5'd1;
      end
      chk("arb_count", bus.count, q.size());
      chk("arb_count_range", (bus.count >= 4) && (bus.count <= 6), 1);
      exp_wr = !exp_wr;
    end
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;

    // Reset in the middle of a write access.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h77;
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    chk("abort_in_wr", bus.ram_cs, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    mw = '0; mr = '0;
    chk("abort_count", bus.count, 0);
    chk("abort_cs", bus.ram_cs, 0);
    chk("abort_oe", bus.ram_wdata_oe, 0);
    chk("abort_empty", bus.empty, 1);
    chk("abort_ovf", bus.ovf_err, 0);

    // Read while empty is ignored.
    bus.rd_req = 1'b1;
    #1 chk("empty_rd_ready", bus.rd_ready, 0);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    chk("empty_no_cs", bus.ram_cs, 0);
    chk("empty_count", bus.count, 0);
    chk("udf_err", bus.udf_err, ERR_EN);
    chk("empty_rd_valid", bus.rd_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
